// File: rtl/rr_arbiter_4ch.sv
// Four-channel round-robin arbiter with hold-while-requested ownership and a bounded hold time.
// Registered grant index/valid/change outputs feed the downstream 2-to-4 select decoder.
module rr_arbiter_4ch #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       gnt_change
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned IDX_W = 2;

  // Last hold count value; with MAX_HOLD == 0 the counter simply saturates and never preempts.
  localparam logic [CNT_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [N_CH-1:0]  owner_mask;
  logic [N_CH-1:0]  others;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] idle_win;
  logic [IDX_W-1:0] hand_win;
  logic             preempt;

  // First set request bit searching upward from p, wrapping mod 4.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CH-1:0]  r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] w;
    w = p;
    for (int i = N_CH - 1; i >= 0; i--) begin
      k = p + IDX_W'(i);
      if (r[k]) w = k;
    end
    return w;
  endfunction

  // Candidate winners for a fresh grant from IDLE and for a hand-over away from the owner.
  always_comb begin
    owner_mask = N_CH'(1) << gnt_idx;
    others     = req & ~owner_mask;
    next_ptr   = gnt_idx + IDX_W'(1);
    idle_win   = rr_pick(req, ptr);
    hand_win   = rr_pick(others, next_ptr);
    preempt    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (|others);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt_idx    <= '0;
      gnt_valid  <= 1'b0;
      gnt_change <= 1'b0;
    end else begin
      gnt_change <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state      <= GRANT;
            gnt_idx    <= idle_win;
            gnt_valid  <= 1'b1;
            gnt_change <= 1'b1;
            hold_cnt   <= '0;
          end
        end
        GRANT: begin
          if (!req[gnt_idx]) begin
            // Owner released: hand over at this edge if anyone else waits, else go idle.
            ptr      <= next_ptr;
            hold_cnt <= '0;
            if (|others) begin
              gnt_idx    <= hand_win;
              gnt_change <= 1'b1;
            end else begin
              state     <= IDLE;
              gnt_valid <= 1'b0;
            end
          end else if (preempt) begin
            ptr        <= next_ptr;
            gnt_idx    <= hand_win;
            gnt_change <= 1'b1;
            hold_cnt   <= '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// Directed bench for rr_arbiter_4ch: reset, rotation, single request, pointer wrap,
// bounded-hold preemption, saturation without competitors and reset mid-grant.
module tb_rr_arbiter_4ch;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       gnt_change;

  int checks = 0;
  int errors = 0;

  rr_arbiter_4ch #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_idx    (gnt_idx),
    .gnt_valid  (gnt_valid),
    .gnt_change (gnt_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares {change, valid, idx} against the hand-computed expectation.
  task automatic chk(input string tag, input logic v, input logic [1:0] idx, input logic c);
    logic [3:0] got;
    logic [3:0] exp;
    got = {gnt_change, gnt_valid, gnt_idx};
    exp = {c, v, idx};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got chg/val/idx=%b/%b/%0d expected %b/%b/%0d",
             tag, got[3], got[2], got[1:0], exp[3], exp[2], exp[1:0]);
    end
  endtask

  initial begin
    // Reset held two clocks with all requests active.
    rst = 1'b1;
    req = 4'b1111;
    tick(); chk("reset_1", 1'b0, 2'd0, 1'b0);
    tick(); chk("reset_2", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    tick(); chk("post_reset_grant", 1'b1, 2'd0, 1'b1);

    // Rotation: each owner drops its request after holding two clocks.
    tick();                 chk("rot_hold0", 1'b1, 2'd0, 1'b0);
    req = 4'b1110; tick();  chk("rot_to1",   1'b1, 2'd1, 1'b1);
    req = 4'b1111; tick();  chk("rot_hold1", 1'b1, 2'd1, 1'b0);
    req = 4'b1101; tick();  chk("rot_to2",   1'b1, 2'd2, 1'b1);
    req = 4'b1111; tick();  chk("rot_hold2", 1'b1, 2'd2, 1'b0);
    req = 4'b1011; tick();  chk("rot_to3",   1'b1, 2'd3, 1'b1);
    req = 4'b1111; tick();  chk("rot_hold3", 1'b1, 2'd3, 1'b0);
    req = 4'b0111; tick();  chk("rot_to0",   1'b1, 2'd0, 1'b1);

    // All requests drop: idle, index keeps last owner.
    req = 4'b0000; tick();  chk("to_idle", 1'b0, 2'd0, 1'b0);

    // Single request on channel 2 for five clocks.
    req = 4'b0100; tick();  chk("single_grant", 1'b1, 2'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("single_hold", 1'b1, 2'd2, 1'b0);
    end
    req = 4'b0000; tick();  chk("single_release", 1'b0, 2'd2, 1'b0);
    tick();                 chk("single_idle", 1'b0, 2'd2, 1'b0);

    // Pointer wrap: owner 3 releases with channels 0 and 2 waiting.
    req = 4'b1000; tick();  chk("wrap_grant3", 1'b1, 2'd3, 1'b1);
    req = 4'b1101; tick();  chk("wrap_hold3",  1'b1, 2'd3, 1'b0);
    req = 4'b0101; tick();  chk("wrap_to0",    1'b1, 2'd0, 1'b1);

    // Preemption: 0 and 1 request continuously, eight cycles each.
    req = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      tick(); chk("pre_hold0", 1'b1, 2'd0, 1'b0);
    end
    tick(); chk("pre_to1", 1'b1, 2'd1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick(); chk("pre_hold1", 1'b1, 2'd1, 1'b0);
    end
    tick(); chk("pre_to0", 1'b1, 2'd0, 1'b1);

    // Lone owner past the hold limit keeps the grant; a competitor then preempts at once.
    req = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick(); chk("lone_hold0", 1'b1, 2'd0, 1'b0);
    end
    req = 4'b0011; tick();  chk("sat_preempt_to1", 1'b1, 2'd1, 1'b1);

    // Reset mid-grant, then channel 1 is re-granted from pointer 0.
    req = 4'b0010; tick();  chk("mid_hold1", 1'b1, 2'd1, 1'b0);
    rst = 1'b1;    tick();  chk("mid_reset", 1'b0, 2'd0, 1'b0);
    rst = 1'b0;    tick();  chk("mid_regrant1", 1'b1, 2'd1, 1'b1);
    tick();                 chk("mid_hold_after", 1'b1, 2'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
